counter_bank: RTL and testbench

COUNTER_BANK -- requirements
Module: counter_bank

---
 rtl/counter_bank_pkg.sv | 18 +
 rtl/counter_bank_cell.sv | 63 ++++++
 rtl/counter_bank.sv | 66 ++++++
 tb/tb_counter_bank.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg
// Shared constants and helpers for the counter bank.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter.
//   calc_chan_w()        : width of a channel index (at least one bit).
package counter_bank_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // A single-channel bank still needs a one-bit select/load index.
  function automatic int calc_chan_w(input int channels);
    if (channels <= 1) begin
      return 1;
    end
    return $clog2(channels);
  endfunction

endpackage

// File: rtl/counter_bank_cell.sv
// counter_cell
// One counter channel with sticky overflow flag.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   clr          : synchronous clear of count and ovf (highest priority)
//   ld, ld_val   : load ld_val and clear ovf (beats inc)
//   inc          : increment; at all-ones either wraps or saturates, sets ovf
//   count, ovf   : registered outputs
module counter_cell
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (ld) begin
      count_d = ld_val;
      ovf_d   = 1'b0;
    end else if (inc) begin
      if (count_q == CNT_MAX) begin
        ovf_d   = 1'b1;
        count_d = (SATURATE == MODE_SAT) ? CNT_MAX : '0;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/counter_bank.sv
// counter_bank
// Bank of CHANNELS independent counters with sticky overflow flags.
// Ports:
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   inc_en[i]        : increment request for channel i
//   load_en, load_chan, load_val : load one channel (out-of-range index ignored)
//   clear_all        : synchronous clear of every counter and flag
//   sel              : read-select index for get_count_ret
//   count            : all counters, channel i at [i*WIDTH +: WIDTH]
//   ovf              : per-channel sticky overflow flags
//   get_count_ret    : count of channel sel, 0 when sel is out of range
//   any_ovf          : OR of all overflow flags
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SATURATE = MODE_WRAP,
  localparam int CHAN_W  = calc_chan_w(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       inc_en,
  input  logic                      load_en,
  input  logic [CHAN_W-1:0]         load_chan,
  input  logic [WIDTH-1:0]          load_val,
  input  logic                      clear_all,
  input  logic [CHAN_W-1:0]         sel,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       ovf,
  output logic [WIDTH-1:0]          get_count_ret,
  output logic                      any_ovf
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    // No channel decodes an index >= CHANNELS, so such loads fall through.
    logic ld_hit;
    assign ld_hit = load_en && (load_chan == CHAN_W'(i));

    counter_cell #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_cell (
      .clock  (clock),
      .reset  (reset),
      .clr    (clear_all),
      .ld     (ld_hit),
      .ld_val (load_val),
      .inc    (inc_en[i]),
      .count  (count[i*WIDTH +: WIDTH]),
      .ovf    (ovf[i])
    );
  end

  always_comb begin
    get_count_ret = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == CHAN_W'(i)) begin
        get_count_ret = count[i*WIDTH +: WIDTH];
      end
    end
  end

  assign any_ovf = |ovf;

endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;
  import counter_bank_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [3:0] inc_en    = '0;
  logic       load_en   = 1'b0;
  logic [1:0] load_chan = '0;
  logic [7:0] load_val  = '0;
  logic       clear_all = 1'b0;
  logic [1:0] sel       = '0;

  logic [31:0] count_a, count_s;
  logic [23:0] count_c;
  logic [3:0]  ovf_a, ovf_s;
  logic [2:0]  ovf_c;
  logic [7:0]  gcr_a, gcr_s, gcr_c;
  logic        any_a, any_s, any_c;

  counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(MODE_WRAP)) dut_a (
    .clock(clock), .reset(reset), .inc_en(inc_en), .load_en(load_en),
    .load_chan(load_chan), .load_val(load_val), .clear_all(clear_all), .sel(sel),
    .count(count_a), .ovf(ovf_a), .get_count_ret(gcr_a), .any_ovf(any_a));

  counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(MODE_SAT)) dut_s (
    .clock(clock), .reset(reset), .inc_en(inc_en), .load_en(load_en),
    .load_chan(load_chan), .load_val(load_val), .clear_all(clear_all), .sel(sel),
    .count(count_s), .ovf(ovf_s), .get_count_ret(gcr_s), .any_ovf(any_s));

  counter_bank #(.WIDTH(8), .CHANNELS(3), .SATURATE(MODE_WRAP)) dut_c (
    .clock(clock), .reset(reset), .inc_en(inc_en[2:0]), .load_en(load_en),
    .load_chan(load_chan), .load_val(load_val), .clear_all(clear_all), .sel(sel),
    .count(count_c), .ovf(ovf_c), .get_count_ret(gcr_c), .any_ovf(any_c));

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: index 0 = wrap/4ch, 1 = saturate/4ch, 2 = wrap/3ch
  int unsigned m_cnt [3][4];
  bit          m_ovf [3][4];
  int          nch   [3] = '{4, 4, 3};
  bit          msat  [3] = '{1'b0, 1'b1, 1'b0};

  typedef struct packed {
    logic [31:0] ca;
    logic [3:0]  oa;
    logic [31:0] cs;
    logic [3:0]  os;
    logic [23:0] cc;
    logic [2:0]  oc;
  } exp_t;

  exp_t sb_q[$];

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 4; i++) begin
        m_cnt[d][i] = 0;
        m_ovf[d][i] = 1'b0;
      end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < nch[d]; i++) begin
        if (clear_all) begin
          m_cnt[d][i] = 0;
          m_ovf[d][i] = 1'b0;
        end else if (load_en && int'(load_chan) == i) begin
          m_cnt[d][i] = load_val;
          m_ovf[d][i] = 1'b0;
        end else if (inc_en[i]) begin
          if (m_cnt[d][i] == 255) begin
            m_ovf[d][i] = 1'b1;
            m_cnt[d][i] = msat[d] ? 255 : 0;
          end else begin
            m_cnt[d][i] = m_cnt[d][i] + 1;
          end
        end
      end
  endtask

  task automatic model_pack(output exp_t e);
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e.ca[i*8 +: 8] = 8'(m_cnt[0][i]);
      e.oa[i]        = m_ovf[0][i];
      e.cs[i*8 +: 8] = 8'(m_cnt[1][i]);
      e.os[i]        = m_ovf[1][i];
    end
    for (int i = 0; i < 3; i++) begin
      e.cc[i*8 +: 8] = 8'(m_cnt[2][i]);
      e.oc[i]        = m_ovf[2][i];
    end
  endtask

  function automatic logic [7:0] exp_sel(input int d);
    if (int'(sel) < nch[d]) return 8'(m_cnt[d][sel]);
    return 8'h00;
  endfunction

  // Drive current inputs for one edge; expected state is queued now and
  // compared once the DUTs have registered it.
  task automatic step();
    exp_t e;
    model_step();
    model_pack(e);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check_val("cnt_a", count_a, e.ca);
    check_val("ovf_a", 32'(ovf_a), 32'(e.oa));
    check_val("any_a", 32'(any_a), 32'(|e.oa));
    check_val("gcr_a", 32'(gcr_a), 32'(exp_sel(0)));
    check_val("cnt_s", count_s, e.cs);
    check_val("ovf_s", 32'(ovf_s), 32'(e.os));
    check_val("any_s", 32'(any_s), 32'(|e.os));
    check_val("gcr_s", 32'(gcr_s), 32'(exp_sel(1)));
    check_val("cnt_c", 32'(count_c), 32'(e.cc));
    check_val("ovf_c", 32'(ovf_c), 32'(e.oc));
    check_val("any_c", 32'(any_c), 32'(|e.oc));
    check_val("gcr_c", 32'(gcr_c), 32'(exp_sel(2)));
  endtask

  task automatic idle_inputs();
    inc_en    = '0;
    load_en   = 1'b0;
    load_chan = '0;
    load_val  = '0;
    clear_all = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] ch, input logic [7:0] v);
    idle_inputs();
    load_en   = 1'b1;
    load_chan = ch;
    load_val  = v;
    step();
    idle_inputs();
  endtask

  initial begin
    model_reset();

    // Reset state, and inputs ignored while reset is held across an edge
    inc_en    = 4'hF;
    clear_all = 1'b0;
    #12;
    check_val("rst_cnt_a", count_a, 32'h0);
    check_val("rst_ovf_s", 32'(ovf_s), 32'h0);
    check_val("rst_cnt_c", 32'(count_c), 32'h0);
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;

    // Basic counting
    inc_en = 4'b0101;
    sel    = 2'd2;
    repeat (3) step();
    check_val("basic_ch0", 32'(count_a[7:0]), 32'd3);
    check_val("basic_ch1", 32'(count_a[15:8]), 32'd0);
    check_val("basic_ch2", 32'(count_a[23:16]), 32'd3);
    check_val("basic_ch3", 32'(count_a[31:24]), 32'd0);
    check_val("basic_sel2", 32'(gcr_a), 32'd3);

    // Wrap
    idle_inputs();
    clear_all = 1'b1;
    step();
    do_load(2'd1, 8'hFE);
    inc_en = 4'b0010;
    repeat (2) step();
    check_val("wrap_ch1", 32'(count_a[15:8]), 32'h00);
    check_val("wrap_ovf", 32'(ovf_a), 32'b0010);
    check_val("wrap_any", 32'(any_a), 32'd1);

    // Saturation; on the 3-channel bank load_chan=3 must do nothing
    do_load(2'd3, 8'hFF);
    inc_en = 4'b1000;
    repeat (5) step();
    check_val("sat_ch3", 32'(count_s[31:24]), 32'hFF);
    check_val("sat_ovf3", 32'(ovf_s[3]), 32'd1);
    sel = 2'd3;
    #1;
    check_val("oor_sel3", 32'(gcr_c), 32'h00);

    // Out-of-range load on the 3-channel bank while it holds nonzero state
    do_load(2'd2, 8'h42);
    do_load(2'd3, 8'h99);
    check_val("oor_load", 32'(count_c), 32'h420000);

    // Priority: clear beats load beats increment
    idle_inputs();
    clear_all = 1'b1;
    load_en   = 1'b1;
    load_chan = 2'd0;
    load_val  = 8'h55;
    inc_en    = 4'hF;
    step();
    check_val("prio_clr_cnt", count_a, 32'h0);
    check_val("prio_clr_ovf", 32'(ovf_a), 32'h0);
    clear_all = 1'b0;
    inc_en    = 4'b0001;
    step();
    check_val("prio_ld_ch0", 32'(count_a[7:0]), 32'h55);

    // Mid-operation reset while ch2 = 7
    do_load(2'd2, 8'h07);
    inc_en = 4'b0100;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    sb_q.delete();
    check_val("midrst_ch2", 32'(count_a[23:16]), 32'h0);
    check_val("midrst_all", count_s, 32'h0);
    @(posedge clock);
    #1;
    check_val("midrst_hold", 32'(count_c), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    step();
    check_val("midrst_resume", 32'(count_a[23:16]), 32'd1);

    // Random traffic, biased toward the all-ones boundary
    for (int n = 0; n < 60; n++) begin
      inc_en    = 4'($urandom);
      load_en   = ($urandom_range(0, 3) == 0);
      load_chan = 2'($urandom);
      load_val  = ($urandom_range(0, 1) == 1) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
      clear_all = ($urandom_range(0, 15) == 0);
      sel       = 2'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
